generic_sram_byte_en_mp: RTL and testbench
==========================================

// Module: generic_sram_byte_en_mp
//
// PURPOSE
//  Multi-port, byte-enabled single-bank SRAM with a built-in round-robin arbiter.
//  N_PORTS requesters share one memory array; one access (read or write) is
//  performed per cycle. Read data returns after a fixed, parameterised latency.
//  Used where several bus slaves or DMA channels need one on-chip scratch RAM.
//
// PARAMETERS
//  MEM_ADDR_BITS  10  word address width; depth = 2**MEM_ADDR_BITS words
//  MEM_DATA_BITS  32  word width; must be a multiple of 8 (lanes = MEM_DATA_BITS/8)
//  N_PORTS        2   requester count, 1..8
//  READ_LATENCY   1   cycles from grant edge to o_rvalid; 1 (array out) or 2 (extra output reg)
//
// PORTS
//  i_clk      in   1                    clock; all logic on rising edge
//  i_rst      in   1                    reset; synchronous, active-high
//  i_req      in   N_PORTS              per-port access request; held until granted
//  i_we       in   N_PORTS              per-port 1=write, 0=read
//  i_addr     in   N_PORTS*ADDR_BITS    per-port word address; port p at [p*AB +: AB]
//  i_byte_en  in   N_PORTS*DATA_BITS/8  per-port byte-lane enables (writes only)
//  i_wdata    in   N_PORTS*DATA_BITS    per-port write data
//  o_gnt      out  N_PORTS              one-hot grant, combinational from i_req and state
//  o_rvalid   out  N_PORTS              one-hot; read data for port p valid this cycle
//  o_rdata    out  DATA_BITS            shared read data, qualified by o_rvalid
//
// BEHAVIOUR
//  Reset: o_rvalid=0, o_rdata=0, latency pipeline cleared, last-grant pointer=N_PORTS-1
//   (port 0 highest priority on first arbitration). Memory array is NOT cleared.
//  Arbitration: round-robin; priority order starts at (last_grant+1) mod N_PORTS.
//   At most one o_gnt bit set; o_gnt=0 when i_req=0 or while i_rst=1.
//   Pointer updates to the granted port on the grant edge; unchanged when idle.
//  Handshake: the transfer occurs on the rising edge where i_req[p] & o_gnt[p].
//   Requester may drop or change its request the cycle after grant.
//   Address, data, we and byte_en are sampled only from the granted port.
//  Write: for each lane b with i_byte_en[b]=1, mem[addr][8b+:8] <= wdata[8b+:8];
//   lanes with enable 0 keep their value. byte_en all-zero = granted no-op write.
//   No write response; o_rvalid not asserted for writes.
//  Read: byte_en ignored, full word returned. Grant at edge T ->
//   o_rvalid[p]=1, o_rdata valid during cycle T+READ_LATENCY, for exactly one cycle.
//   Back-to-back reads from any mix of ports return in grant order, one per cycle.
//   o_rdata holds its last value when o_rvalid=0.
//  Ordering: read granted the cycle after a write to the same address returns new data.
//  Addresses wrap naturally at 2**MEM_ADDR_BITS (no out-of-range case).
//  Reset mid-operation: in-flight reads are dropped (no o_rvalid); pending requests
//   must be re-arbitrated after reset deasserts.
//  Elaboration: $error if MEM_DATA_BITS%8!=0, N_PORTS outside 1..8,
//   or READ_LATENCY not in {1,2}.
//
// TESTING
//  1. N=2, L=1: P0 write addr 5 = 0xDEADBEEF, be=4'hF; then P0 read 5 -> o_rvalid=2'b01
//     one cycle after read grant, o_rdata=0xDEADBEEF.
//  2. Byte lanes: addr 5 = 0xDEADBEEF; write 0x11223344 be=4'b0101 -> read gives 0xDE22BE44;
//     write be=4'b0000 -> unchanged.
//  3. Arbitration: P0,P1 request reads continuously from reset -> grants 01,10,01,10...;
//     rvalid follows the same sequence, lagged by L.
//  4. L=2, N=4: all four ports read distinct preloaded addresses at once -> grants P0..P3
//     on consecutive cycles; each rvalid exactly 2 cycles after its grant, correct data.
//  5. Reset mid-read: assert i_rst the cycle after a read grant -> no o_rvalid,
//     o_rdata=0, next arbitration grants port 0 first; memory contents preserved.
//  6. Write-then-read hazard: P1 writes addr 0x3FF = 0xA5A5A5A5, P0 reads 0x3FF next cycle
//     -> 0xA5A5A5A5; random multi-port traffic vs scoreboard model, no mismatches.

Source files
------------

// File: rtl/generic_sram_byte_en_mp_if.sv
// Requester-side bus for the shared byte-enabled SRAM: per-port request fields
// packed side by side, plus one-hot grant/valid and the shared read data.
interface generic_sram_byte_en_mp_if #(
   parameter int ADDR_BITS = 10,
   parameter int DATA_BITS = 32,
   parameter int N_PORTS   = 2
);
   logic [N_PORTS-1:0]               i_req;
   logic [N_PORTS-1:0]               i_we;
   logic [N_PORTS*ADDR_BITS-1:0]     i_addr;
   logic [N_PORTS*(DATA_BITS/8)-1:0] i_byte_en;
   logic [N_PORTS*DATA_BITS-1:0]     i_wdata;
   logic [N_PORTS-1:0]               o_gnt;
   logic [N_PORTS-1:0]               o_rvalid;
   logic [DATA_BITS-1:0]             o_rdata;

   modport master (
      output i_req, i_we, i_addr, i_byte_en, i_wdata,
      input  o_gnt, o_rvalid, o_rdata
   );

   modport slave (
      input  i_req, i_we, i_addr, i_byte_en, i_wdata,
      output o_gnt, o_rvalid, o_rdata
   );
endinterface

// File: rtl/generic_sram_byte_en_mp.sv
// Single-bank byte-enabled SRAM shared by N_PORTS requesters through a
// round-robin arbiter; one access per cycle, reads return after READ_LATENCY.
module generic_sram_byte_en_mp #(
   parameter int MEM_ADDR_BITS = 10,
   parameter int MEM_DATA_BITS = 32,
   parameter int N_PORTS       = 2,
   parameter int READ_LATENCY  = 1
) (
   input logic                      i_clk,
   input logic                      i_rst,
   generic_sram_byte_en_mp_if.slave bus
);
   localparam int LANES = MEM_DATA_BITS / 8;
   localparam int PW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int DEPTH = 2 ** MEM_ADDR_BITS;

   if (MEM_DATA_BITS % 8 != 0) begin : g_bad_width
      $error("MEM_DATA_BITS must be a multiple of 8");
   end
   if (N_PORTS < 1 || N_PORTS > 8) begin : g_bad_ports
      $error("N_PORTS must be in 1..8");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
   end

   logic [MEM_DATA_BITS-1:0] mem [DEPTH];

   logic [PW-1:0]            last_grant;
   logic [PW-1:0]            gnt_idx;
   logic                     gnt_any;
   logic [N_PORTS-1:0]       gnt;
   logic [MEM_ADDR_BITS-1:0] sel_addr;
   logic [MEM_DATA_BITS-1:0] sel_wdata;
   logic [LANES-1:0]         sel_be;
   logic                     sel_we;
   logic                     rd_fire;
   logic [N_PORTS-1:0]       s1_valid;
   logic [MEM_DATA_BITS-1:0] s1_data;

   function automatic logic [PW-1:0] wrap_port(input int v);
      return PW'(v % N_PORTS);
   endfunction

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int i = 1; i <= N_PORTS; i++) begin
         if (!gnt_any && bus.i_req[wrap_port(int'(last_grant) + i)]) begin
            gnt_any = 1'b1;
            gnt_idx = wrap_port(int'(last_grant) + i);
         end
      end
      if (i_rst) gnt_any = 1'b0;
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end

   assign bus.o_gnt = gnt;
   assign sel_addr  = bus.i_addr[gnt_idx*MEM_ADDR_BITS +: MEM_ADDR_BITS];
   assign sel_wdata = bus.i_wdata[gnt_idx*MEM_DATA_BITS +: MEM_DATA_BITS];
   assign sel_be    = bus.i_byte_en[gnt_idx*LANES +: LANES];
   assign sel_we    = bus.i_we[gnt_idx];
   assign rd_fire   = gnt_any && !sel_we;

   // The array itself is never reset; contents survive i_rst.
   always_ff @(posedge i_clk) begin
      if (gnt_any && sel_we) begin
         for (int b = 0; b < LANES; b++) begin
            if (sel_be[b]) mem[sel_addr][8*b +: 8] <= sel_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid   <= '0;
         s1_data    <= '0;
         last_grant <= PW'(N_PORTS - 1);
      end else begin
         s1_valid <= rd_fire ? gnt : '0;
         if (rd_fire) s1_data <= mem[sel_addr];
         if (gnt_any) last_grant <= gnt_idx;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic [N_PORTS-1:0]       s2_valid;
      logic [MEM_DATA_BITS-1:0] s2_data;

      // Data register only loads on a valid beat so o_rdata holds between reads.
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            s2_valid <= '0;
            s2_data  <= '0;
         end else begin
            s2_valid <= s1_valid;
            if (|s1_valid) s2_data <= s1_data;
         end
      end

      assign bus.o_rvalid = s2_valid;
      assign bus.o_rdata  = s2_data;
   end else begin : g_lat1
      assign bus.o_rvalid = s1_valid;
      assign bus.o_rdata  = s1_data;
   end
endmodule

// File: tb/tb_generic_sram_byte_en_mp.sv
// Directed bench for the shared SRAM: a 2-port latency-1 instance and a
// 4-port latency-2 instance, plus scoreboarded random traffic on the first.
module tb_generic_sram_byte_en_mp;
   logic i_clk = 1'b0;
   logic i_rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 i_clk = ~i_clk;

   generic_sram_byte_en_mp_if #(.ADDR_BITS(10), .DATA_BITS(32), .N_PORTS(2)) bus_a ();
   generic_sram_byte_en_mp_if #(.ADDR_BITS(10), .DATA_BITS(32), .N_PORTS(4)) bus_b ();

   generic_sram_byte_en_mp #(
      .MEM_ADDR_BITS(10), .MEM_DATA_BITS(32), .N_PORTS(2), .READ_LATENCY(1)
   ) dut_a (
      .i_clk(i_clk), .i_rst(i_rst), .bus(bus_a)
   );

   generic_sram_byte_en_mp #(
      .MEM_ADDR_BITS(10), .MEM_DATA_BITS(32), .N_PORTS(4), .READ_LATENCY(2)
   ) dut_b (
      .i_clk(i_clk), .i_rst(i_rst), .bus(bus_b)
   );

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_a();
      bus_a.i_req = '0; bus_a.i_we = '0; bus_a.i_addr = '0;
      bus_a.i_byte_en = '0; bus_a.i_wdata = '0;
   endtask

   task automatic idle_b();
      bus_b.i_req = '0; bus_b.i_we = '0; bus_b.i_addr = '0;
      bus_b.i_byte_en = '0; bus_b.i_wdata = '0;
   endtask

   task automatic drive_a(input int p, input logic we, input logic [9:0] addr,
                          input logic [3:0] be, input logic [31:0] d);
      bus_a.i_req[p] = 1'b1;
      bus_a.i_we[p]  = we;
      bus_a.i_addr[p*10 +: 10]   = addr;
      bus_a.i_byte_en[p*4 +: 4]  = be;
      bus_a.i_wdata[p*32 +: 32]  = d;
   endtask

   task automatic drive_b(input int p, input logic we, input logic [9:0] addr,
                          input logic [3:0] be, input logic [31:0] d);
      bus_b.i_req[p] = 1'b1;
      bus_b.i_we[p]  = we;
      bus_b.i_addr[p*10 +: 10]   = addr;
      bus_b.i_byte_en[p*4 +: 4]  = be;
      bus_b.i_wdata[p*32 +: 32]  = d;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      idle_a(); idle_b();
      bus_a.i_req = 2'b11;
      bus_b.i_req = 4'hF;
      cyc(); cyc(); #1;
      checks++; if (bus_a.o_gnt !== 2'b00) begin failures++; $display("[TB] FAIL reset_gnt_a got=%b exp=00", bus_a.o_gnt); end
      checks++; if (bus_b.o_gnt !== 4'h0) begin failures++; $display("[TB] FAIL reset_gnt_b got=%b exp=0000", bus_b.o_gnt); end
      checks++; if (bus_a.o_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL reset_rvalid_a got=%b exp=00", bus_a.o_rvalid); end
      checks++; if (bus_a.o_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata_a got=%h exp=0", bus_a.o_rdata); end
      checks++; if (bus_b.o_rvalid !== 4'h0) begin failures++; $display("[TB] FAIL reset_rvalid_b got=%b exp=0000", bus_b.o_rvalid); end
      checks++; if (bus_b.o_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata_b got=%h exp=0", bus_b.o_rdata); end
      i_rst = 1'b0;
      idle_a(); idle_b();
      cyc();
   endtask

   task automatic test_write_read();
      drive_a(0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
      #1;
      checks++; if (bus_a.o_gnt !== 2'b01) begin failures++; $display("[TB] FAIL wr_gnt got=%b exp=01", bus_a.o_gnt); end
      cyc(); idle_a(); #1;
      checks++; if (bus_a.o_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL wr_no_rvalid got=%b exp=00", bus_a.o_rvalid); end
      drive_a(0, 1'b0, 10'd5, 4'h0, 32'h0);
      #1;
      checks++; if (bus_a.o_gnt !== 2'b01) begin failures++; $display("[TB] FAIL rd_gnt got=%b exp=01", bus_a.o_gnt); end
      cyc(); idle_a(); #1;
      checks++; if (bus_a.o_rvalid !== 2'b01) begin failures++; $display("[TB] FAIL rd_rvalid got=%b exp=01", bus_a.o_rvalid); end
      checks++; if (bus_a.o_rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rd_data got=%h exp=deadbeef", bus_a.o_rdata); end
      cyc(); #1;
      checks++; if (bus_a.o_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL rd_one_cycle got=%b exp=00", bus_a.o_rvalid); end
      checks++; if (bus_a.o_rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rd_hold got=%h exp=deadbeef", bus_a.o_rdata); end
   endtask

   task automatic test_byte_lanes();
      drive_a(0, 1'b1, 10'd5, 4'b0101, 32'h11223344); cyc(); idle_a();
      drive_a(0, 1'b0, 10'd5, 4'h0, 32'h0); cyc(); idle_a(); #1;
      checks++; if (bus_a.o_rdata !== 32'hDE22BE44) begin failures++; $display("[TB] FAIL be_0101 got=%h exp=de22be44", bus_a.o_rdata); end
      drive_a(1, 1'b1, 10'd5, 4'b0000, 32'hFFFFFFFF); cyc(); idle_a();
      drive_a(1, 1'b0, 10'd5, 4'h0, 32'h0); cyc(); idle_a(); #1;
      checks++; if (bus_a.o_rvalid !== 2'b10) begin failures++; $display("[TB] FAIL be_p1_rvalid got=%b exp=10", bus_a.o_rvalid); end
      checks++; if (bus_a.o_rdata !== 32'hDE22BE44) begin failures++; $display("[TB] FAIL be_0000 got=%h exp=de22be44", bus_a.o_rdata); end
      drive_a(1, 1'b1, 10'd5, 4'b1010, 32'h99887766); cyc(); idle_a();
      drive_a(0, 1'b0, 10'd5, 4'h0, 32'h0); cyc(); idle_a(); #1;
      checks++; if (bus_a.o_rdata !== 32'h99227744) begin failures++; $display("[TB] FAIL be_1010_p1 got=%h exp=99227744", bus_a.o_rdata); end
   endtask

   task automatic test_arbitration();
      logic [1:0] exp_g;
      logic [1:0] exp_v;
      drive_a(1, 1'b1, 10'd6, 4'hF, 32'h600D600D); cyc(); idle_a();
      i_rst = 1'b1; cyc(); i_rst = 1'b0;
      drive_a(0, 1'b0, 10'd5, 4'h0, 32'h0);
      drive_a(1, 1'b0, 10'd6, 4'h0, 32'h0);
      for (int k = 0; k <= 6; k++) begin
         if (k == 6) idle_a();
         #1;
         exp_g = (k == 6) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
         exp_v = (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
         checks++; if (bus_a.o_gnt !== exp_g) begin failures++; $display("[TB] FAIL rr_gnt[%0d] got=%b exp=%b", k, bus_a.o_gnt, exp_g); end
         checks++; if (bus_a.o_rvalid !== exp_v) begin failures++; $display("[TB] FAIL rr_rvalid[%0d] got=%b exp=%b", k, bus_a.o_rvalid, exp_v); end
         if (exp_v != 2'b00) begin
            checks++;
            if (bus_a.o_rdata !== ((exp_v == 2'b01) ? 32'h99227744 : 32'h600D600D)) begin
               failures++; $display("[TB] FAIL rr_rdata[%0d] got=%h", k, bus_a.o_rdata);
            end
         end
         cyc();
      end
      idle_a();
   endtask

   task automatic test_four_ports();
      logic [3:0]  exp_g;
      logic [3:0]  exp_v;
      logic [31:0] exp_d;
      for (int p = 0; p < 4; p++) begin
         drive_b(p, 1'b1, 10'(16 + p), 4'hF, 32'hC0DE0000 + 32'(p));
         cyc(); idle_b();
      end
      for (int p = 0; p < 4; p++) drive_b(p, 1'b0, 10'(16 + p), 4'h0, 32'h0);
      for (int k = 0; k < 8; k++) begin
         #1;
         exp_g = (k < 4) ? 4'(1 << k) : 4'h0;
         exp_v = (k >= 2 && k < 6) ? 4'(1 << (k - 2)) : 4'h0;
         checks++; if (bus_b.o_gnt !== exp_g) begin failures++; $display("[TB] FAIL l2_gnt[%0d] got=%b exp=%b", k, bus_b.o_gnt, exp_g); end
         checks++; if (bus_b.o_rvalid !== exp_v) begin failures++; $display("[TB] FAIL l2_rvalid[%0d] got=%b exp=%b", k, bus_b.o_rvalid, exp_v); end
         if (exp_v != 4'h0) begin
            exp_d = 32'hC0DE0000 + 32'(k - 2);
            checks++; if (bus_b.o_rdata !== exp_d) begin failures++; $display("[TB] FAIL l2_rdata[%0d] got=%h exp=%h", k, bus_b.o_rdata, exp_d); end
         end
         cyc();
         if (k < 4) bus_b.i_req[k] = 1'b0;
      end
      idle_b();
   endtask

   task automatic test_reset_mid_read();
      drive_b(2, 1'b0, 10'd18, 4'h0, 32'h0);
      #1;
      checks++; if (bus_b.o_gnt !== 4'b0100) begin failures++; $display("[TB] FAIL mid_gnt got=%b exp=0100", bus_b.o_gnt); end
      cyc(); idle_b();
      i_rst = 1'b1;
      for (int p = 0; p < 4; p++) drive_b(p, 1'b0, 10'(16 + p), 4'h0, 32'h0);
      #1;
      checks++; if (bus_b.o_gnt !== 4'h0) begin failures++; $display("[TB] FAIL mid_gnt_in_rst got=%b exp=0000", bus_b.o_gnt); end
      cyc(); #1;
      checks++; if (bus_b.o_rvalid !== 4'h0) begin failures++; $display("[TB] FAIL mid_dropped got=%b exp=0000", bus_b.o_rvalid); end
      checks++; if (bus_b.o_rdata !== 32'h0) begin failures++; $display("[TB] FAIL mid_rdata got=%h exp=0", bus_b.o_rdata); end
      cyc(); #1;
      checks++; if (bus_b.o_rvalid !== 4'h0) begin failures++; $display("[TB] FAIL mid_dropped2 got=%b exp=0000", bus_b.o_rvalid); end
      i_rst = 1'b0;
      #1;
      checks++; if (bus_b.o_gnt !== 4'b0001) begin failures++; $display("[TB] FAIL post_rst_gnt got=%b exp=0001", bus_b.o_gnt); end
      cyc(); idle_b(); cyc(); #1;
      checks++; if (bus_b.o_rvalid !== 4'b0001) begin failures++; $display("[TB] FAIL post_rst_rvalid got=%b exp=0001", bus_b.o_rvalid); end
      checks++; if (bus_b.o_rdata !== 32'hC0DE0000) begin failures++; $display("[TB] FAIL mem_kept got=%h exp=c0de0000", bus_b.o_rdata); end
   endtask

   task automatic test_hazard();
      drive_a(1, 1'b1, 10'h3FF, 4'hF, 32'hA5A5A5A5);
      #1;
      checks++; if (bus_a.o_gnt !== 2'b10) begin failures++; $display("[TB] FAIL hz_wr_gnt got=%b exp=10", bus_a.o_gnt); end
      cyc(); idle_a();
      drive_a(0, 1'b0, 10'h3FF, 4'h0, 32'h0);
      #1;
      checks++; if (bus_a.o_gnt !== 2'b01) begin failures++; $display("[TB] FAIL hz_rd_gnt got=%b exp=01", bus_a.o_gnt); end
      cyc(); idle_a(); #1;
      checks++; if (bus_a.o_rvalid !== 2'b01) begin failures++; $display("[TB] FAIL hz_rvalid got=%b exp=01", bus_a.o_rvalid); end
      checks++; if (bus_a.o_rdata !== 32'hA5A5A5A5) begin failures++; $display("[TB] FAIL hz_rdata got=%h exp=a5a5a5a5", bus_a.o_rdata); end
   endtask

   task automatic test_random_traffic();
      logic [31:0] model [8];
      logic [31:0] v;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [2:0]  ad;
      logic [1:0]  exp_g;
      logic [1:0]  exp_v;
      int          ptr;
      int          g;
      int          idx;
      logic        pv;
      int          pp;
      logic [31:0] pd;
      i_rst = 1'b1; cyc(); i_rst = 1'b0;
      for (int a = 0; a < 8; a++) begin
         v = $urandom;
         model[a] = v;
         drive_a(0, 1'b1, 10'(a), 4'hF, v); cyc(); idle_a();
      end
      ptr = 0;
      pv  = 1'b0;
      pp  = 0;
      pd  = '0;
      for (int i = 0; i < 200; i++) begin
         idle_a();
         for (int p = 0; p < 2; p++) begin
            if ($urandom_range(0, 1) == 1)
               drive_a(p, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)),
                       4'($urandom_range(0, 15)), $urandom);
         end
         #1;
         g = -1;
         for (int j = 1; j <= 2; j++) begin
            idx = (ptr + j) % 2;
            if (g < 0 && bus_a.i_req[idx]) g = idx;
         end
         exp_g = (g < 0) ? 2'b00 : 2'(1 << g);
         exp_v = pv ? 2'(1 << pp) : 2'b00;
         checks++; if (bus_a.o_gnt !== exp_g) begin failures++; $display("[TB] FAIL rnd_gnt[%0d] got=%b exp=%b", i, bus_a.o_gnt, exp_g); end
         checks++; if (bus_a.o_rvalid !== exp_v) begin failures++; $display("[TB] FAIL rnd_rvalid[%0d] got=%b exp=%b", i, bus_a.o_rvalid, exp_v); end
         if (pv) begin
            checks++; if (bus_a.o_rdata !== pd) begin failures++; $display("[TB] FAIL rnd_rdata[%0d] got=%h exp=%h", i, bus_a.o_rdata, pd); end
         end
         pv = 1'b0;
         if (g >= 0) begin
            ptr = g;
            ad  = bus_a.i_addr[g*10 +: 3];
            if (bus_a.i_we[g]) begin
               be = bus_a.i_byte_en[g*4 +: 4];
               wd = bus_a.i_wdata[g*32 +: 32];
               for (int b = 0; b < 4; b++) if (be[b]) model[ad][8*b +: 8] = wd[8*b +: 8];
            end else begin
               pv = 1'b1;
               pp = g;
               pd = model[ad];
            end
         end
         cyc();
      end
      idle_a();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      i_rst = 1'b1;
      idle_a();
      idle_b();
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_arbitration();
      test_four_ports();
      test_reset_mid_read();
      test_hazard();
      test_random_traffic();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
